uart_tx_fifo: RTL and testbench

UART transmitter with a small input FIFO, pairing with the existing UART receiver on the same 50 MHz clock domain. Upstream logic pushes bytes with a valid/full handshake. The block serialises each byte as an 8N1 frame on `uart_txd`, sending frames back-to-back while the FIFO holds data. It sits between the image/command logic and the board TX pin, and its output must be receivable by the team's receiver at the same `UART_BPS`.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int FIFO_AW  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(BPS_CNT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   fifo_cnt_reg;
    logic               push;
    logic               pop;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_inc;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             txd_reg, txd_next;
    logic             bit_end;

    // Full/empty come from the registered count, so a pop frees space one cycle later.
    assign tx_full  = (fifo_cnt_reg == CNT_FULL);
    assign tx_empty = (fifo_cnt_reg == '0);
    assign push     = tx_valid & ~tx_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (FIFO_AW + 1)'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (FIFO_AW + 1)'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end

    assign bit_end = (count_reg == CNT_MAX);
    assign bit_inc = bit_cnt_reg + 3'd1;

    // The line level for the coming cycle is decided here and registered,
    // so uart_txd never glitches and follows the state by one edge.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                txd_next   = 1'b1;
                if (!tx_empty) begin
                    pop           = 1'b1;
                    tx_shift_next = fifo_mem[rd_ptr_reg];
                    state_next    = START;
                    txd_next      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    count_next   = '0;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                    txd_next     = tx_shift_reg[0];
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    count_next = '0;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_inc;
                        txd_next     = tx_shift_reg[bit_inc];
                    end
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    count_next = '0;
                    if (!tx_empty) begin
                        pop           = 1'b1;
                        tx_shift_next = fifo_mem[rd_ptr_reg];
                        state_next    = START;
                        txd_next      = 1'b0;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    assign tx_done  = (state_reg == STOP) && bit_end;
    assign tx_busy  = (state_reg != IDLE);
    assign uart_txd = txd_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: a frame-level reference model
// predicts the line and flags; a serial monitor decodes frames against a queue.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 70_000;
    localparam int B        = CLK_FREQ / UART_BPS;   // 14 cycles per bit
    localparam int FRAME    = 10 * B;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_full, tx_empty, tx_busy, tx_done, uart_txd;

    logic [7:0] s_data = 8'h01;
    logic       s_valid = 1'b0;
    logic       s_full, s_empty, s_busy, s_done, s_txd;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FIFO_AW(2)) dut (
        .clk(clk), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .tx_done(tx_done), .uart_txd(uart_txd)
    );

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .UART_BPS(9600), .FIFO_AW(2)) dut_9600 (
        .clk(clk), .clr(clr), .tx_data(s_data), .tx_valid(s_valid),
        .tx_full(s_full), .tx_empty(s_empty), .tx_busy(s_busy),
        .tx_done(s_done), .uart_txd(s_txd)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit rst_done = 1'b0;
    bit param_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents plus position inside the current frame.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    int         m_done_cnt = 0;
    int         rx_frames = 0;

    initial begin : model
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                m_q.delete();
                exp_q.delete();
                m_active = 1'b0;
                m_t = 0;
            end else begin
                bit full_b, push_b, done_b, pop_b;
                full_b = (m_q.size() == DEPTH);
                push_b = tx_valid && !full_b;
                done_b = m_active && (m_t == FRAME - 1);
                pop_b  = (!m_active || done_b) && (m_q.size() > 0);
                if (done_b) m_done_cnt++;
                if (pop_b) begin
                    m_cur = m_q.pop_front();
                    m_active = 1'b1;
                    m_t = 0;
                    exp_q.push_back(m_cur);
                end else if (done_b) begin
                    m_active = 1'b0;
                end else if (m_active) begin
                    m_t++;
                end
                if (push_b) m_q.push_back(tx_data);
            end
        end
    end

    function automatic logic exp_txd();
        if (!m_active) return 1'b1;
        if (m_t < B) return 1'b0;
        if (m_t < 9 * B) return m_cur[(m_t - B) / B];
        return 1'b1;
    endfunction

    initial begin : cycle_check
        forever begin
            @(negedge clk);
            if (clr && rst_done) begin
                check("txd", uart_txd, exp_txd());
                check("busy", tx_busy, m_active);
                check("done", tx_done, m_active && (m_t == FRAME - 1));
                check("full", tx_full, m_q.size() == DEPTH);
                check("empty", tx_empty, m_q.size() == 0);
            end
        end
    end

    // Serial monitor: samples mid-bit and pops the scoreboard at each stop bit.
    initial begin : monitor
        int rt;
        bit rx_busy;
        logic [7:0] sh;
        rt = 0;
        rx_busy = 1'b0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (!clr || !rst_done) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (uart_txd === 1'b0) begin
                    rx_busy = 1'b1;
                    rt = 0;
                end
            end else begin
                rt++;
                if (rt == B / 2) begin
                    check("rx_start_bit", uart_txd, 1'b0);
                end else if (rt > B && rt < 9 * B && (rt % B) == B / 2) begin
                    sh[(rt / B) - 1] = uart_txd;
                end else if (rt == 9 * B + B / 2) begin
                    check("rx_stop_bit", uart_txd, 1'b1);
                    check("rx_frame_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) check("rx_byte", sh, exp_q.pop_front());
                    rx_frames++;
                    rx_busy = 1'b0;
                end
            end
        end
    end

    initial begin : param_test
        int w, n;
        w = 0;
        n = 0;
        wait (rst_done);
        @(posedge clk); #1 s_valid = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        while (s_txd !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("bps9600_start_seen", s_txd, 1'b0);
        while (s_txd === 1'b0 && w < 6000) begin @(negedge clk); w++; end
        check("bps9600_bit_width", w, 5208);
        param_done = 1'b1;
    end

    initial begin : watchdog
        #(60_000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        $display("push 0x%02h at %0t", d, $time);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((tx_busy || !tx_empty) && n < budget) begin @(posedge clk); #1; n++; end
        check("drain_timeout", tx_busy || !tx_empty, 1'b0);
    endtask

    initial begin : stimulus
        int n, len;
        #1 clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", tx_full, 1'b0);
        check("rst_empty", tx_empty, 1'b1);
        #2 clr = 1'b1;
        rst_done = 1'b1;
        @(posedge clk); #1;

        // Single byte: latency, frame length, busy release.
        push(8'h55);
        @(negedge clk);
        check("lat_edge_n_idle", uart_txd, 1'b1);
        @(negedge clk);
        check("lat_edge_n1_low", uart_txd, 1'b0);
        check("lat_busy", tx_busy, 1'b1);
        len = 1;
        while (tx_done !== 1'b1 && len < 2 * FRAME) begin @(negedge clk); len++; end
        check("frame_len", len, FRAME);
        @(negedge clk);
        check("busy_after_done", tx_busy, 1'b0);
        @(posedge clk); #1;

        // Consecutive pushes, sent back-to-back.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_idle(6 * FRAME);
        check("burst_empty", tx_empty, 1'b1);
        check("burst_busy", tx_busy, 1'b0);

        // Overflow: writes while full, including during the STOP pop cycle.
        push(8'h11);
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        check("ovf_full", tx_full, 1'b1);
        push(8'hFF);
        check("ovf_still_full", tx_full, 1'b1);
        n = 0;
        @(negedge clk);
        while (tx_done !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        check("ovf_done_seen", tx_done, 1'b1);
        check("ovf_full_at_pop", tx_full, 1'b1);
        tx_data  = 8'hFE;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("ovf_full_after_pop", tx_full, 1'b0);
        wait_idle(6 * FRAME);

        // Loopback bytes.
        push(8'hA3); push(8'h00); push(8'hFF);
        wait_idle(5 * FRAME);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tx_valid = ($urandom_range(0, 19) == 0);
            tx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        wait_idle(6 * FRAME);

        // Reset during data bit 3 of 0xC3.
        n = 0;
        while (!param_done && n < 8000) begin @(posedge clk); #1; n++; end
        check("param_test_finished", param_done, 1'b1);
        push(8'hC3);
        repeat (1 + 4 * B + B / 2) @(negedge clk);
        check("pre_rst_line_low", uart_txd, 1'b0);
        clr = 1'b0;
        #1;
        check("mid_rst_txd", uart_txd, 1'b1);
        check("mid_rst_empty", tx_empty, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        n = 0;
        len = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) n++;
            if (uart_txd !== 1'b1) len++;
        end
        check("post_rst_no_done", n, 0);
        check("post_rst_line_idle", len, 0);

        check("rx_frame_count", rx_frames, m_done_cnt);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
